// File: rtl/shop_engine_mp_if.sv
// ---------------------------------------------------------------------------
// shop_engine_mp_if -- buy request / purchase result bundle for shop_engine_mp.
//
// Signals (NUM_PLAYERS lanes, player p in lane p):
//   buy_valid    request strobe, one request per high cycle
//   buy_code     flattened item codes, player p at [p*CODE_W +: CODE_W]
//   grant        one-cycle pulse: purchase succeeded
//   grant_code   item code that was granted (0 when no grant)
//   charged      amount debited for the grant (0 when no grant)
//   err_invalid  pulse: item code out of range
//   err_stock    pulse: item out of stock
//   err_credit   pulse: insufficient credit
//
// Modports: master = player/request side, slave = shop engine.
// ---------------------------------------------------------------------------
interface shop_engine_mp_if #(
   parameter int NUM_PLAYERS = 2,
   parameter int CODE_W      = 3,
   parameter int CREDIT_W    = 10
);
   logic [NUM_PLAYERS-1:0]          buy_valid;
   logic [NUM_PLAYERS*CODE_W-1:0]   buy_code;
   logic [NUM_PLAYERS-1:0]          grant;
   logic [NUM_PLAYERS*CODE_W-1:0]   grant_code;
   logic [NUM_PLAYERS*CREDIT_W-1:0] charged;
   logic [NUM_PLAYERS-1:0]          err_invalid;
   logic [NUM_PLAYERS-1:0]          err_stock;
   logic [NUM_PLAYERS-1:0]          err_credit;

   modport master (
      output buy_valid, buy_code,
      input  grant, grant_code, charged, err_invalid, err_stock, err_credit
   );

   modport slave (
      input  buy_valid, buy_code,
      output grant, grant_code, charged, err_invalid, err_stock, err_credit
   );
endinterface

// File: rtl/shop_engine_mp.sv
// ---------------------------------------------------------------------------
// shop_engine_mp -- shop-phase purchase engine for NUM_PLAYERS players.
//
// Tracks per-player credit and item stock (per-player counters or one shared
// pool per item), applies the last round winner's moves-to-win discount and
// arbitrates shared-stock contention round-robin.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   phase_shop    requests are accepted only while high
//   price_flat    base prices, item i at [i*CREDIT_W +: CREDIT_W]
//   disc_load     pulse: latch disc_winner / disc_moves as the new discount
//   disc_winner   winning player index
//   disc_moves    moves-to-win of the finished round
//   credit_flat   current credits, player p at [p*CREDIT_W +: CREDIT_W]
//   stock_flat    shared pool (shared mode) or player 0's counters
//   bus           request/result bundle (slave side)
//
// Every request sampled at a clock edge is resolved combinationally and its
// result registered at that same edge together with credit/stock updates.
// ---------------------------------------------------------------------------
module shop_engine_mp #(
   parameter int NUM_PLAYERS  = 2,
   parameter int NUM_ITEMS    = 5,
   parameter int CODE_W       = 3,
   parameter int CREDIT_W     = 10,
   parameter int STOCK_W      = 3,
   parameter int INIT_CREDIT  = 500,
   parameter int INIT_STOCK   = 5,
   parameter int SHARED_STOCK = 0,
   parameter int BAND1_MAX    = 6,
   parameter int BAND2_MAX    = 9,
   parameter int MULT1        = 80,
   parameter int MULT2        = 90,
   parameter int MULT3        = 95
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            phase_shop,
   input  logic [NUM_ITEMS*CREDIT_W-1:0]   price_flat,
   input  logic                            disc_load,
   input  logic [1:0]                      disc_winner,
   input  logic [7:0]                      disc_moves,
   output logic [NUM_PLAYERS*CREDIT_W-1:0] credit_flat,
   output logic [NUM_ITEMS*STOCK_W-1:0]    stock_flat,
   shop_engine_mp_if.slave                 bus
);

   localparam int PIDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
   localparam int MUL_W  = CREDIT_W + 7;

   typedef logic [PIDX_W-1:0]   pidx_t;
   typedef logic [PIDX_W:0]     pos_t;
   typedef logic [CODE_W-1:0]   code_t;
   typedef logic [CODE_W:0]     codex_t;
   typedef logic [CREDIT_W-1:0] credit_t;
   typedef logic [STOCK_W-1:0]  stock_t;
   typedef logic [MUL_W-1:0]    wide_t;
   typedef logic [6:0]          mult_t;

   // state
   credit_t credit_q [NUM_PLAYERS];
   stock_t  stock_q  [NUM_PLAYERS][NUM_ITEMS];
   pidx_t   rr_ptr;
   mult_t   mult_q;
   logic [1:0] winner_q;

   // registered results
   logic [NUM_PLAYERS-1:0] grant_q, err_inv_q, err_stk_q, err_cr_q;
   code_t   gcode_q   [NUM_PLAYERS];
   credit_t charged_q [NUM_PLAYERS];

   // next-state / next-result
   credit_t credit_d [NUM_PLAYERS];
   stock_t  stock_d  [NUM_PLAYERS][NUM_ITEMS];
   pidx_t   rr_d;
   logic [NUM_PLAYERS-1:0] grant_d, err_inv_d, err_stk_d, err_cr_d;
   code_t   gcode_d   [NUM_PLAYERS];
   credit_t charged_d [NUM_PLAYERS];

   // unpacked views of the flat inputs
   code_t   code_a  [NUM_PLAYERS];
   credit_t price_a [NUM_ITEMS];

   // per-cycle arbitration bookkeeping
   logic [NUM_ITEMS-1:0] item_hit;
   pidx_t   item_win [NUM_ITEMS];
   logic    cont;
   pidx_t   cont_win;
   pos_t    pos;
   pidx_t   p, s;
   code_t   c;
   mult_t   m;
   wide_t   eff;

   always_comb begin
      for (int unsigned q = 0; q < NUM_PLAYERS; q++)
         code_a[q] = bus.buy_code[q*CODE_W +: CODE_W];
      for (int unsigned i = 0; i < NUM_ITEMS; i++)
         price_a[i] = price_flat[i*CREDIT_W +: CREDIT_W];
   end

   // Requests are walked in priority order starting at rr_ptr. Each one sees
   // the stock/credit left over by the requests ahead of it, so grants within
   // a cycle can never overdraw a pool or a credit balance.
   always_comb begin
      credit_d  = credit_q;
      stock_d   = stock_q;
      rr_d      = rr_ptr;
      grant_d   = '0;
      err_inv_d = '0;
      err_stk_d = '0;
      err_cr_d  = '0;
      for (int unsigned q = 0; q < NUM_PLAYERS; q++) begin
         gcode_d[q]   = '0;
         charged_d[q] = '0;
      end
      item_hit = '0;
      for (int unsigned i = 0; i < NUM_ITEMS; i++)
         item_win[i] = '0;
      cont     = 1'b0;
      cont_win = '0;
      pos      = '0;
      p        = '0;
      s        = '0;
      c        = '0;
      m        = '0;
      eff      = '0;

      if (phase_shop) begin
         for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
            pos = pos_t'(rr_ptr) + pos_t'(k);
            if (pos >= pos_t'(NUM_PLAYERS))
               pos = pos - pos_t'(NUM_PLAYERS);
            p = pidx_t'(pos);
            c = code_a[p];
            s = (SHARED_STOCK != 0) ? '0 : p;
            m = (winner_q == 2'(p)) ? mult_q : 7'd100;
            if (bus.buy_valid[p]) begin
               if (codex_t'(c) >= codex_t'(NUM_ITEMS)) begin
                  err_inv_d[p] = 1'b1;
               end else begin
                  eff = (wide_t'(price_a[c]) * wide_t'(m)) / wide_t'(100);
                  if (stock_d[s][c] == '0) begin
                     err_stk_d[p] = 1'b1;
                     // lost to an earlier grant of the same pool item
                     if ((SHARED_STOCK != 0) && item_hit[c]) begin
                        cont     = 1'b1;
                        cont_win = item_win[c];
                     end
                  end else if (eff > wide_t'(credit_d[p])) begin
                     err_cr_d[p] = 1'b1;
                  end else begin
                     grant_d[p]    = 1'b1;
                     gcode_d[p]    = c;
                     charged_d[p]  = credit_t'(eff);
                     credit_d[p]   = credit_d[p] - credit_t'(eff);
                     stock_d[s][c] = stock_d[s][c] - stock_t'(1);
                     item_hit[c]   = 1'b1;
                     item_win[c]   = p;
                  end
               end
            end
         end

         if (cont) begin
            pos = pos_t'(cont_win) + pos_t'(1);
            if (pos >= pos_t'(NUM_PLAYERS))
               pos = '0;
            rr_d = pidx_t'(pos);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned q = 0; q < NUM_PLAYERS; q++) begin
            credit_q[q]  <= credit_t'(INIT_CREDIT);
            gcode_q[q]   <= '0;
            charged_q[q] <= '0;
            for (int unsigned i = 0; i < NUM_ITEMS; i++)
               stock_q[q][i] <= stock_t'(INIT_STOCK);
         end
         rr_ptr    <= '0;
         mult_q    <= 7'd100;
         winner_q  <= '0;
         grant_q   <= '0;
         err_inv_q <= '0;
         err_stk_q <= '0;
         err_cr_q  <= '0;
      end else begin
         credit_q  <= credit_d;
         stock_q   <= stock_d;
         rr_ptr    <= rr_d;
         grant_q   <= grant_d;
         gcode_q   <= gcode_d;
         charged_q <= charged_d;
         err_inv_q <= err_inv_d;
         err_stk_q <= err_stk_d;
         err_cr_q  <= err_cr_d;
         // buys in this same cycle already used the old multiplier above
         if (disc_load) begin
            winner_q <= disc_winner;
            if (disc_moves <= 8'(BAND1_MAX))
               mult_q <= mult_t'(MULT1);
            else if (disc_moves <= 8'(BAND2_MAX))
               mult_q <= mult_t'(MULT2);
            else
               mult_q <= mult_t'(MULT3);
         end
      end
   end

   assign bus.grant       = grant_q;
   assign bus.err_invalid = err_inv_q;
   assign bus.err_stock   = err_stk_q;
   assign bus.err_credit  = err_cr_q;

   always_comb begin
      for (int unsigned q = 0; q < NUM_PLAYERS; q++) begin
         bus.grant_code[q*CODE_W +: CODE_W] = gcode_q[q];
         bus.charged[q*CREDIT_W +: CREDIT_W] = charged_q[q];
         credit_flat[q*CREDIT_W +: CREDIT_W] = credit_q[q];
      end
      for (int unsigned i = 0; i < NUM_ITEMS; i++)
         stock_flat[i*STOCK_W +: STOCK_W] = stock_q[0][i];
   end

endmodule

// File: tb/tb_shop_engine_mp.sv
// ---------------------------------------------------------------------------
// tb_shop_engine_mp -- bench for shop_engine_mp.
//   dut_a: defaults (2 players, per-player stock, INIT_STOCK 5)
//   dut_b: 3 players, shared stock pool, INIT_STOCK 1
// Expected results come from a purchase-rule model; a monitor pops and
// compares one expected record per DUT per cycle.
// ---------------------------------------------------------------------------
module tb_shop_engine_mp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [49:0] PRICES = {10'd30, 10'd50, 10'd50, 10'd120, 10'd100};
   int price_m [5] = '{100, 120, 50, 50, 30};

   // stimulus variables, index 0 = dut_a, 1 = dut_b
   bit       rst_v   [2];
   bit       phase_v [2];
   bit [3:0] valid_v [2];
   int       code_v  [2][4];
   bit       dload_v [2];
   int       dwin_v  [2];
   int       dmov_v  [2];

   shop_engine_mp_if #(.NUM_PLAYERS(2), .CODE_W(3), .CREDIT_W(10)) a_if ();
   shop_engine_mp_if #(.NUM_PLAYERS(3), .CODE_W(3), .CREDIT_W(10)) b_if ();

   logic [19:0] a_credit;
   logic [14:0] a_stock;
   logic [29:0] b_credit;
   logic [14:0] b_stock;

   assign a_if.buy_valid = valid_v[0][1:0];
   assign a_if.buy_code  = {3'(code_v[0][1]), 3'(code_v[0][0])};
   assign b_if.buy_valid = valid_v[1][2:0];
   assign b_if.buy_code  = {3'(code_v[1][2]), 3'(code_v[1][1]), 3'(code_v[1][0])};

   shop_engine_mp dut_a (
      .clk(clk), .rst(rst_v[0]), .phase_shop(phase_v[0]), .price_flat(PRICES),
      .disc_load(dload_v[0]), .disc_winner(2'(dwin_v[0])), .disc_moves(8'(dmov_v[0])),
      .credit_flat(a_credit), .stock_flat(a_stock), .bus(a_if.slave)
   );

   shop_engine_mp #(.NUM_PLAYERS(3), .SHARED_STOCK(1), .INIT_STOCK(1)) dut_b (
      .clk(clk), .rst(rst_v[1]), .phase_shop(phase_v[1]), .price_flat(PRICES),
      .disc_load(dload_v[1]), .disc_winner(2'(dwin_v[1])), .disc_moves(8'(dmov_v[1])),
      .credit_flat(b_credit), .stock_flat(b_stock), .bus(b_if.slave)
   );

   typedef struct {
      logic [63:0] g, gc, ch, ei, es, ec, cr, st;
   } rec_t;

   rec_t qa[$];
   rec_t qb[$];
   int checks = 0;
   int errors = 0;

   // reference state
   int credit_m [2][4];
   int stock_m  [2][4][5];
   int rr_m     [2];
   int mult_m   [2];
   int win_m    [2];

   function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endfunction

   function automatic void clr();
      for (int d = 0; d < 2; d++) begin
         rst_v[d] = 0; phase_v[d] = 1; valid_v[d] = '0; dload_v[d] = 0;
         dwin_v[d] = 0; dmov_v[d] = 0;
         for (int q = 0; q < 4; q++) code_v[d][q] = 0;
      end
   endfunction

   // One clock edge of purchase rules for DUT d.
   task automatic model(input int d, output rec_t e);
      int np, ist, p, c, mul, eff, s, cw;
      bit sh, cont;
      int granted [5];
      int winner  [5];
      np  = (d == 0) ? 2 : 3;
      sh  = (d == 1);
      ist = (d == 0) ? 5 : 1;
      e = '{default: '0};
      if (rst_v[d]) begin
         for (int q = 0; q < 4; q++) begin
            credit_m[d][q] = 500;
            for (int i = 0; i < 5; i++) stock_m[d][q][i] = ist;
         end
         rr_m[d] = 0; mult_m[d] = 100; win_m[d] = 0;
      end else begin
         if (phase_v[d]) begin
            cont = 0; cw = 0;
            for (int i = 0; i < 5; i++) begin granted[i] = 0; winner[i] = 0; end
            for (int k = 0; k < np; k++) begin
               p = (rr_m[d] + k) % np;
               if (!valid_v[d][p]) continue;
               c = code_v[d][p];
               if (c >= 5) begin e.ei[p] = 1; continue; end
               mul = (p == win_m[d]) ? mult_m[d] : 100;
               eff = (price_m[c] * mul) / 100;
               s = sh ? 0 : p;
               if (stock_m[d][s][c] == 0) begin
                  e.es[p] = 1;
                  if (sh && granted[c] > 0) begin cont = 1; cw = winner[c]; end
               end else if (eff > credit_m[d][p]) begin
                  e.ec[p] = 1;
               end else begin
                  e.g[p] = 1;
                  e.gc |= 64'(c) << (p * 3);
                  e.ch |= 64'(eff) << (p * 10);
                  credit_m[d][p] -= eff;
                  stock_m[d][s][c] -= 1;
                  granted[c] += 1;
                  winner[c] = p;
               end
            end
            if (cont) rr_m[d] = (cw + 1) % np;
         end
         if (dload_v[d]) begin
            mult_m[d] = (dmov_v[d] <= 6) ? 80 : (dmov_v[d] <= 9) ? 90 : 95;
            win_m[d]  = dwin_v[d];
         end
      end
      for (int q = 0; q < np; q++) e.cr |= 64'(credit_m[d][q]) << (q * 10);
      for (int i = 0; i < 5; i++) e.st |= 64'(stock_m[d][0][i]) << (i * 3);
   endtask

   // called at posedge+2; returns at the next posedge+2
   task automatic tick();
      rec_t ea, eb;
      model(0, ea); qa.push_back(ea);
      model(1, eb); qb.push_back(eb);
      @(posedge clk);
      #2;
   endtask

   function automatic void cmp(string tag, rec_t e, rec_t a);
      chk({tag, "_grant"},      a.g,  e.g);
      chk({tag, "_grant_code"}, a.gc, e.gc);
      chk({tag, "_charged"},    a.ch, e.ch);
      chk({tag, "_err_invalid"},a.ei, e.ei);
      chk({tag, "_err_stock"},  a.es, e.es);
      chk({tag, "_err_credit"}, a.ec, e.ec);
      chk({tag, "_credit"},     a.cr, e.cr);
      chk({tag, "_stock"},      a.st, e.st);
   endfunction

   // monitor
   initial begin
      rec_t e, a;
      forever begin
         @(posedge clk);
         #1;
         if (qa.size() > 0) begin
            e = qa.pop_front();
            a.g = 64'(a_if.grant); a.gc = 64'(a_if.grant_code); a.ch = 64'(a_if.charged);
            a.ei = 64'(a_if.err_invalid); a.es = 64'(a_if.err_stock); a.ec = 64'(a_if.err_credit);
            a.cr = 64'(a_credit); a.st = 64'(a_stock);
            cmp("a", e, a);
         end
         if (qb.size() > 0) begin
            e = qb.pop_front();
            a.g = 64'(b_if.grant); a.gc = 64'(b_if.grant_code); a.ch = 64'(b_if.charged);
            a.ei = 64'(b_if.err_invalid); a.es = 64'(b_if.err_stock); a.ec = 64'(b_if.err_credit);
            a.cr = 64'(b_credit); a.st = 64'(b_stock);
            cmp("b", e, a);
         end
      end
   end

   // stimulus
   initial begin
      clr();
      rst_v[0] = 1; rst_v[1] = 1;
      tick(); tick();
      chk("rst_credit0", 64'(a_credit[9:0]), 500);
      chk("rst_grant", 64'(a_if.grant), 0);
      chk("rst_stock4", 64'(a_stock[14:12]), 5);

      clr(); valid_v[0] = 4'b0001; code_v[0][0] = 5; tick();
      chk("inv_pulse", 64'(a_if.err_invalid), 1);
      chk("inv_nogrant", 64'(a_if.grant), 0);
      chk("inv_credit", 64'(a_credit[9:0]), 500);
      clr(); tick();
      chk("inv_width", 64'(a_if.err_invalid), 0);

      repeat (5) begin clr(); valid_v[0] = 4'b0001; code_v[0][0] = 4; tick(); end
      chk("buy4_credit", 64'(a_credit[9:0]), 350);
      chk("buy4_stock", 64'(a_stock[14:12]), 0);
      clr(); valid_v[0] = 4'b0001; code_v[0][0] = 4; tick();
      chk("stock_err", 64'(a_if.err_stock), 1);
      chk("stock_err_credit", 64'(a_credit[9:0]), 350);

      foreach (price_m[i]) ;
      for (int j = 0; j < 5; j++) begin
         int seq [5] = '{2, 3, 3, 3, 0};
         clr(); valid_v[0] = 4'b0001; code_v[0][0] = seq[j]; tick();
      end
      chk("credit_50", 64'(a_credit[9:0]), 50);
      clr(); valid_v[0] = 4'b0001; code_v[0][0] = 1; tick();
      chk("credit_err", 64'(a_if.err_credit), 1);
      clr(); valid_v[0] = 4'b0001; code_v[0][0] = 2; tick();
      chk("exact_grant", 64'(a_if.grant), 1);
      chk("exact_credit", 64'(a_credit[9:0]), 0);

      clr(); rst_v[0] = 1; tick();
      clr(); dload_v[0] = 1; dwin_v[0] = 1; dmov_v[0] = 8; tick();
      clr(); valid_v[0] = 4'b0011; tick();
      chk("disc90_p1", 64'(a_if.charged[19:10]), 90);
      chk("disc_p0_full", 64'(a_if.charged[9:0]), 100);
      clr(); dload_v[0] = 1; dwin_v[0] = 1; dmov_v[0] = 6; valid_v[0] = 4'b0010; tick();
      chk("disc_same_cycle", 64'(a_if.charged[19:10]), 90);
      clr(); valid_v[0] = 4'b0010; tick();
      chk("disc80", 64'(a_if.charged[19:10]), 80);
      clr(); dload_v[0] = 1; dwin_v[0] = 1; dmov_v[0] = 12; tick();
      clr(); valid_v[0] = 4'b0010; tick();
      chk("disc95", 64'(a_if.charged[19:10]), 95);

      clr(); valid_v[1] = 4'b0011; code_v[1][0] = 2; code_v[1][1] = 2; tick();
      chk("pool_grant", 64'(b_if.grant), 3'b001);
      chk("pool_stock_err", 64'(b_if.err_stock), 3'b010);
      clr(); valid_v[1] = 4'b0011; code_v[1][0] = 3; code_v[1][1] = 3; tick();
      chk("rr_grant", 64'(b_if.grant), 3'b010);
      chk("rr_stock_err", 64'(b_if.err_stock), 3'b001);
      clr(); phase_v[1] = 0; valid_v[1] = 4'b0111; tick();
      chk("phase_off_grant", 64'(b_if.grant), 0);
      chk("phase_off_err", 64'(b_if.err_stock), 0);
      chk("phase_off_credit", 64'(b_credit[19:0]), {10'd450, 10'd450});
      chk("phase_off_stock0", 64'(b_stock[2:0]), 1);

      for (int n = 0; n < 1500; n++) begin
         clr();
         for (int d = 0; d < 2; d++) begin
            rst_v[d]   = ($urandom_range(0, 99) == 0);
            phase_v[d] = ($urandom_range(0, 9) != 0);
            valid_v[d] = 4'($urandom);
            for (int q = 0; q < 4; q++)
               code_v[d][q] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 7))
                                                          : int'($urandom_range(0, 4));
            dload_v[d] = ($urandom_range(0, 19) == 0);
            dwin_v[d]  = int'($urandom_range(0, 3));
            dmov_v[d]  = int'($urandom_range(0, 15));
         end
         tick();
      end
      clr();

      for (int w = 0; w < 10 && (qa.size() + qb.size()) != 0; w++) @(posedge clk);
      #3;
      chk("scoreboard_drain", 64'(qa.size() + qb.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
